ppu_vram_subsystem: RTL and testbench

- PPU video-memory block: a dual-port VRAM, a pixel-to-nametable pointer translator, and a nametable-to-attribute pointer translator.
- Port A is the CPU/loader read-write port. Port B is the render-FSM read port.
- The combinational translators give the renderer the nametable byte address, the fine-row offset, and the attribute byte address and quadrant for the current pixel.

---
 rtl/ppu_vram_subsystem.sv | 86 ++++++++
 tb/tb_ppu_vram_subsystem.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_subsystem.sv
// PPU video memory: dual-port VRAM (A = CPU read/write, B = render read) plus the
// combinational pixel->nametable and nametable->attribute pointer translators.
module ppu_vram_subsystem #(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic [7:0]        a_rdata,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [7:0]        b_rdata,
    input  logic [8:0]        curr_row,
    input  logic [8:0]        curr_col,
    input  logic [15:0]       cpu_scroll_addr,
    input  logic [7:0]        ppu_ctrl1,
    output logic [15:0]       nametable_ptr,
    output logic [2:0]        pattern_table_offset,
    output logic [15:0]       attr_ptr,
    output logic [1:0]        attr_shift
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       a_rdata_q;
    logic [7:0]       b_rdata_q;
    logic [IDX_W-1:0] a_idx;
    logic [IDX_W-1:0] b_idx;

    // Upper address bits are dropped so accesses wrap modulo DEPTH.
    assign a_idx = a_addr[IDX_W-1:0];
    assign b_idx = b_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst && a_we) begin
            mem_q[a_idx] <= a_wdata;
        end
    end

    // Both reads sample the array before this edge's write lands: read-first on A,
    // old-data on a same-address B collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            a_rdata_q <= mem_q[a_idx];
            b_rdata_q <= mem_q[b_idx];
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

    logic [9:0] x_sum;
    logic [9:0] y_sum;
    logic [9:0] y_adj;
    logic       y_wrap;
    logic       ht;
    logic       vt;
    logic [4:0] tile_x;
    logic [4:0] tile_y;

    assign x_sum  = {1'b0, curr_col} + {2'b00, cpu_scroll_addr[15:8]};
    assign y_sum  = {1'b0, curr_row} + {2'b00, cpu_scroll_addr[7:0]};
    assign y_wrap = (y_sum >= 10'd240);
    assign y_adj  = y_wrap ? (y_sum - 10'd240) : y_sum;
    assign ht     = ppu_ctrl1[0] ^ (x_sum >= 10'd256);
    assign vt     = ppu_ctrl1[1] ^ y_wrap;
    assign tile_x = x_sum[7:3];
    assign tile_y = y_adj[7:3];

    assign nametable_ptr        = 16'h2000 + {4'b0000, vt, ht, tile_y, tile_x};
    assign pattern_table_offset = y_adj[2:0];

    // Each attribute byte covers a 4x4-tile block; the quadrant is tile bit 1 in x and y.
    assign attr_ptr   = {nametable_ptr[15:10], 4'b1111, nametable_ptr[9:7], nametable_ptr[4:2]};
    assign attr_shift = {nametable_ptr[6], nametable_ptr[1]};

    logic unused_bits;
    assign unused_bits = ^{a_addr[ADDR_W-1:IDX_W], b_addr[ADDR_W-1:IDX_W],
                           ppu_ctrl1[7:2], x_sum[9:8], y_adj[9:8]};

endmodule

// File: tb/tb_ppu_vram_subsystem.sv
// Directed bench for ppu_vram_subsystem: RAM reads are scoreboarded against a shadow
// memory, translator outputs against hand-derived constants and an arithmetic model.
module tb_ppu_vram_subsystem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_addr = '0;
    logic [7:0]  a_wdata = '0;
    logic [7:0]  a_rdata;
    logic        a_we = 1'b0;
    logic [15:0] b_addr = '0;
    logic [7:0]  b_rdata;
    logic [8:0]  curr_row = '0;
    logic [8:0]  curr_col = '0;
    logic [15:0] cpu_scroll_addr = '0;
    logic [7:0]  ppu_ctrl1 = '0;
    logic [15:0] nametable_ptr;
    logic [2:0]  pattern_table_offset;
    logic [15:0] attr_ptr;
    logic [1:0]  attr_shift;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_mem [int];
    logic [8:0] exp_a_q [$];
    logic [8:0] exp_b_q [$];

    ppu_vram_subsystem #(.DEPTH(16384), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_we(a_we),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .curr_row(curr_row), .curr_col(curr_col),
        .cpu_scroll_addr(cpu_scroll_addr), .ppu_ctrl1(ppu_ctrl1),
        .nametable_ptr(nametable_ptr), .pattern_table_offset(pattern_table_offset),
        .attr_ptr(attr_ptr), .attr_shift(attr_shift)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] expect_rd(input logic [15:0] addr);
        int idx = int'(addr) % 16384;
        if (ref_mem.exists(idx)) return {1'b1, ref_mem[idx]};
        return 9'h000;
    endfunction

    // One clock: drive ports, push the expected registered reads, then compare after the edge.
    task automatic ram_cycle(input logic we, input logic [15:0] aa, input logic [7:0] wd,
                             input logic [15:0] ba);
        logic [8:0] ea, eb;
        a_we = we; a_addr = aa; a_wdata = wd; b_addr = ba;
        if (rst) begin
            exp_a_q.push_back(9'h100);
            exp_b_q.push_back(9'h100);
        end else begin
            exp_a_q.push_back(expect_rd(aa));
            exp_b_q.push_back(expect_rd(ba));
            if (we) ref_mem[int'(aa) % 16384] = wd;
        end
        @(posedge clk);
        #1;
        a_we = 1'b0;
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        if (ea[8]) chk("a_rdata", {8'h00, a_rdata}, {8'h00, ea[7:0]});
        if (eb[8]) chk("b_rdata", {8'h00, b_rdata}, {8'h00, eb[7:0]});
    endtask

    task automatic set_tr(input int row, input int col, input int sx, input int sy, input int ctrl);
        curr_row = row[8:0]; curr_col = col[8:0];
        cpu_scroll_addr = {sx[7:0], sy[7:0]}; ppu_ctrl1 = ctrl[7:0];
        #1;
    endtask

    task automatic tr_model(input int row, input int col, input int sx, input int sy, input int ctrl,
                            output int ptr, output int off, output int aptr, output int ash);
        int x, y, ht, vt, tx, ty;
        x = col + sx; y = row + sy;
        ht = ctrl & 1; vt = (ctrl >> 1) & 1;
        if (x >= 256) begin ht = 1 - ht; x = x - 256; end
        if (y >= 240) begin vt = 1 - vt; y = y - 240; end
        tx = x / 8; ty = y / 8;
        ptr  = 'h2000 + vt * 'h800 + ht * 'h400 + ty * 32 + tx;
        off  = y % 8;
        aptr = (ptr & 'hFC00) | 'h3C0 | ((ty / 4) * 8) | (tx / 4);
        ash  = ((ty / 2) % 2) * 2 + ((tx / 2) % 2);
    endtask

    initial begin
        int ptr, off, aptr, ash, r, c, sx, sy, ct;

        // Reset held 10 cycles with a write attempted throughout: outputs zero, no write.
        rst = 1'b1;
        for (int i = 0; i < 10; i++) ram_cycle(1'b1, 16'h0300, 8'h99, 16'h0300);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) ram_cycle(1'b1, 16'(i), 8'hFF, 16'h0000);
        for (int i = 16'h1010; i <= 16'h101F; i++) ram_cycle(1'b1, 16'(i), 8'hFF, 16'h0000);
        ram_cycle(1'b1, 16'h2001, 8'h01, 16'h0000);
        ram_cycle(1'b1, 16'h23C0, 8'h0C, 16'h0000);
        ram_cycle(1'b1, 16'h0100, 8'hAA, 16'h0000);
        ram_cycle(1'b1, 16'h0300, 8'h11, 16'h0000);

        ram_cycle(1'b0, 16'h0000, 8'h00, 16'h1015);
        chk("b_1015", {8'h00, b_rdata}, 16'h00FF);
        ram_cycle(1'b0, 16'h001F, 8'h00, 16'h2001);
        chk("b_2001", {8'h00, b_rdata}, 16'h0001);
        chk("a_001F", {8'h00, a_rdata}, 16'h00FF);
        ram_cycle(1'b0, 16'h0000, 8'h00, 16'h23C0);
        chk("b_23C0", {8'h00, b_rdata}, 16'h000C);

        // Second reset: a write attempt during reset must not land; contents survive.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) ram_cycle(1'b1, 16'h0300, 8'h99, 16'h23C0);
        rst = 1'b0;
        ram_cycle(1'b0, 16'h0300, 8'h00, 16'h23C0);
        chk("post_rst_a_0300", {8'h00, a_rdata}, 16'h0011);
        chk("post_rst_b_23C0", {8'h00, b_rdata}, 16'h000C);

        // Collision: A writes 0x55 over 0xAA while B reads the same word.
        ram_cycle(1'b1, 16'h0100, 8'h55, 16'h0100);
        chk("coll_b_old", {8'h00, b_rdata}, 16'h00AA);
        chk("coll_a_old", {8'h00, a_rdata}, 16'h00AA);
        ram_cycle(1'b0, 16'h0100, 8'h00, 16'h0100);
        chk("coll_b_new", {8'h00, b_rdata}, 16'h0055);
        chk("coll_a_new", {8'h00, a_rdata}, 16'h0055);

        ram_cycle(1'b1, 16'h4005, 8'h77, 16'h0000);
        ram_cycle(1'b0, 16'hC005, 8'h00, 16'h0005);
        chk("wrap_b_0005", {8'h00, b_rdata}, 16'h0077);
        chk("wrap_a_C005", {8'h00, a_rdata}, 16'h0077);

        set_tr(0, 8, 0, 0, 0);
        chk("base_ptr", nametable_ptr, 16'h2001);
        chk("base_off", {13'h0, pattern_table_offset}, 16'h0000);
        chk("base_aptr", attr_ptr, 16'h23C0);
        chk("base_ash", {14'h0, attr_shift}, 16'h0000);

        // tile (12,1): quadrant bits are tile_x[1]=0, tile_y[1]=0.
        set_tr(13, 100, 0, 0, 0);
        chk("r13_ptr", nametable_ptr, 16'h202C);
        chk("r13_off", {13'h0, pattern_table_offset}, 16'h0005);
        chk("r13_aptr", attr_ptr, 16'h23C3);
        chk("r13_ash", {14'h0, attr_shift}, 16'h0000);

        // x = 250 + 16 = 266 crosses into the right table, tile_x = 1.
        set_tr(0, 250, 16, 0, 0);
        chk("sx_ptr", nametable_ptr, 16'h2401);

        // y = 235 + 16 = 251 wraps to y' = 11: tile_y 1, fine row 3, lower table.
        set_tr(235, 40, 0, 16, 0);
        chk("sy_ptr", nametable_ptr, 16'h2825);
        chk("sy_off", {13'h0, pattern_table_offset}, 16'h0003);

        set_tr(0, 0, 0, 0, 3);
        chk("ctl3_ptr", nametable_ptr, 16'h2C00);
        chk("ctl3_aptr", attr_ptr, 16'h2FC0);

        // Both wraps against a base table that already selects the right/bottom table.
        set_tr(239, 255, 255, 255, 3);
        tr_model(239, 255, 255, 255, 3, ptr, off, aptr, ash);
        chk("max_ptr", nametable_ptr, 16'(ptr));
        chk("max_aptr", attr_ptr, 16'(aptr));

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(239, 0); c = $urandom_range(255, 0);
            sx = $urandom_range(255, 0); sy = $urandom_range(255, 0);
            ct = $urandom_range(255, 0);
            set_tr(r, c, sx, sy, ct);
            tr_model(r, c, sx, sy, ct, ptr, off, aptr, ash);
            chk("rnd_ptr", nametable_ptr, 16'(ptr));
            chk("rnd_off", {13'h0, pattern_table_offset}, 16'(off));
            chk("rnd_aptr", attr_ptr, 16'(aptr));
            chk("rnd_ash", {14'h0, attr_shift}, 16'(ash));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
